// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32 data memory with valid/ready handshake, wait states and post-reset clear walk
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module dmem_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_access,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        clr_busy
);
    localparam int              IW      = ADDR_WIDTH - 2;
    localparam int              DEPTH   = 2 ** IW;
    localparam bit              NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0]      WS_INIT = 4'(WAIT_STATES);
    localparam logic [IW-1:0]   IDX_ONE = IW'(1);

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  r_state, w_next;
    logic [IW-1:0]           r_clr_idx;
    logic [3:0]              r_wait_cnt;
    logic                    r_load, r_store;
    logic [2:0]              r_access;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic                    r_fault;
    logic [31:0]             r_mem [DEPTH];

    logic                    w_accept, w_do_access;
    logic                    w_load, w_store;
    logic [2:0]              w_access;
    logic [1:0]              w_size;
    logic [ADDR_WIDTH-1:0]   w_addr_raw, w_addr_eff;
    logic [31:0]             w_wdata;
    logic [IW-1:0]           w_widx;
    logic [1:0]              w_lane;
    logic                    w_fault, w_fault_mis;
    logic [31:0]             w_word, w_ld_data, w_wd;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [3:0]              w_be;
    logic                    w_unused_addr;

    assign w_unused_addr = ^req_addr[31:ADDR_WIDTH];

    // With no wait states the access happens on the accept edge, straight from the request inputs.
    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_do_access = NO_WAIT ? w_accept : ((r_state == S_WAIT) && (r_wait_cnt == 4'd1));
    assign w_load      = NO_WAIT ? req_load   : r_load;
    assign w_store     = NO_WAIT ? req_store  : r_store;
    assign w_access    = NO_WAIT ? req_access : r_access;
    assign w_addr_raw  = NO_WAIT ? req_addr[ADDR_WIDTH-1:0] : r_addr;
    assign w_wdata     = NO_WAIT ? req_wdata  : r_wdata;
    assign w_size      = w_access[1:0];

    always_comb begin
        w_addr_eff = w_addr_raw;
        if (w_size == 2'b01) w_addr_eff[0] = 1'b0;
        if (w_size == 2'b10) w_addr_eff[1:0] = 2'b00;
    end

    assign w_widx = w_addr_eff[ADDR_WIDTH-1:2];
    assign w_lane = w_addr_eff[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_fault_mis = ((w_size == 2'b01) && w_addr_raw[0]) ||
                         ((w_size == 2'b10) && (w_addr_raw[1:0] != 2'b00));
`else
    assign w_fault_mis = 1'b0;
`endif

    assign w_fault = (w_load == w_store) ||
                     (w_load && ((w_access == 3'b011) || (w_access == 3'b110) || (w_access == 3'b111))) ||
                     (w_store && (w_access[2] || (w_size == 2'b11))) ||
                     w_fault_mis;

    assign w_word = r_mem[w_widx];
    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (w_size)
            2'b00:   w_ld_data = {{24{~w_access[2] & w_byte[7]}}, w_byte};
            2'b01:   w_ld_data = {{16{~w_access[2] & w_half[15]}}, w_half};
            default: w_ld_data = w_word;
        endcase
    end

    always_comb begin
        case (w_size)
            2'b00:   begin w_be = 4'b0001 << w_lane; w_wd = {4{w_wdata[7:0]}}; end
            2'b01:   begin w_be = w_lane[1] ? 4'b1100 : 4'b0011; w_wd = {2{w_wdata[15:0]}}; end
            default: begin w_be = 4'b1111; w_wd = w_wdata; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_idx == '1) w_next = S_IDLE;
            S_IDLE:  if (req_valid) w_next = NO_WAIT ? S_RESP : S_WAIT;
            S_WAIT:  if (r_wait_cnt == 4'd1) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_CLEAR;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        clr_busy   = (r_state == S_CLEAR);
        resp_rdata = resp_valid ? r_rdata : 32'h0;
        resp_fault = resp_valid & r_fault;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx  <= '0;
            r_wait_cnt <= 4'd0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_access   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_fault    <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + IDX_ONE;
            if (w_accept) begin
                r_load     <= req_load;
                r_store    <= req_store;
                r_access   <= req_access;
                r_addr     <= req_addr[ADDR_WIDTH-1:0];
                r_wdata    <= req_wdata;
                r_wait_cnt <= WS_INIT;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_do_access) begin
                r_fault <= w_fault;
                r_rdata <= (w_fault || w_store) ? 32'h0 : w_ld_data;
            end
        end
    end

    // Single write port shared by the clear walk and store accesses; reset suppresses both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_idx] <= 32'h0;
            end else if (w_do_access && w_store && !w_fault) begin
                if (w_be[0]) r_mem[w_widx][7:0]   <= w_wd[7:0];
                if (w_be[1]) r_mem[w_widx][15:8]  <= w_wd[15:8];
                if (w_be[2]) r_mem[w_widx][23:16] <= w_wd[23:16];
                if (w_be[3]) r_mem[w_widx][31:24] <= w_wd[31:24];
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-array reference model
module tb_dmem_ctrl;
    localparam int WS = 1;
    localparam int AW = 12;

    logic        clk, rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_access;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault, clr_busy;
    logic [31:0] resp_rdata;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;

    typedef struct {
        logic [31:0] rd;
        logic        f;
    } exp_t;
    exp_t q[$];

    logic [7:0] mem_m [4096];

    dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_access(req_access),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .clr_busy(clr_busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", nm, act, req, $time);
        end
    endfunction

    // Reference: byte-addressed memory, spec fault rules, size from access[1:0].
    function automatic void model_access(input logic ld, input logic st, input logic [2:0] acc,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic f);
        int a, n;
        a  = int'(addr[11:0]);
        rd = 32'h0;
        f  = 1'b0;
        if (ld == st) f = 1'b1;
        else if (ld && (acc == 3'b011 || acc == 3'b110 || acc == 3'b111)) f = 1'b1;
        else if (st && (acc[2] || acc[1:0] == 2'b11)) f = 1'b1;
        n = (acc[1:0] == 2'b00) ? 1 : (acc[1:0] == 2'b01) ? 2 : 4;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!f && (a % n) != 0) f = 1'b1;
`endif
        if (f) return;
        a = a - (a % n);
        if (st) begin
            for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < n; i++) rd = rd | (32'(mem_m[a + i]) << (8 * i));
            if (!acc[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk(!(resp_valid && req_ready), "ready_excl_valid", {31'b0, req_ready}, 32'h0);
            if (clr_busy) chk(!req_ready && !resp_valid, "clear_quiet", {30'b0, req_ready, resp_valid}, 32'h0);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_resp", resp_rdata, 32'h0);
                end else begin
                    chk(resp_rdata == q[0].rd, "resp_rdata", resp_rdata, q[0].rd);
                    chk(resp_fault == q[0].f, "resp_fault", {31'b0, resp_fault}, {31'b0, q[0].f});
                    if (resp_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic do_reset(input bit sync_first);
        int n;
        if (sync_first) begin @(posedge clk); #1; end
        rst = 1; req_valid = 0; resp_ready = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4096; i++) mem_m[i] = 8'h0;
        q.delete();
        chk(clr_busy === 1'b1, "rst_clr_busy", {31'b0, clr_busy}, 32'h1);
        chk(req_ready === 1'b0 && resp_valid === 1'b0, "rst_ready_valid", {30'b0, req_ready, resp_valid}, 32'h0);
        chk(resp_rdata === 32'h0, "rst_rdata", resp_rdata, 32'h0);
        chk(resp_fault === 1'b0, "rst_fault", {31'b0, resp_fault}, 32'h0);
        n = 0;
        while (clr_busy && n < 3000) begin
            @(negedge clk);
            if (clr_busy) n++;
        end
        chk(n == 1024, "clear_cycles", n, 1024);
        chk(req_ready === 1'b1, "ready_after_clear", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic do_req(input logic ld, input logic st, input logic [2:0] acc,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input logic [31:0] lit_rd, input logic lit_f);
        exp_t        e;
        int          k;
        logic [31:0] got_rd;
        logic        got_f;
        k = 0;
        while (!req_ready && k < 2000) begin @(posedge clk); #1; k++; end
        chk(req_ready, "ready_before_req", {31'b0, req_ready}, 32'h1);
        req_valid = 1; req_load = ld; req_store = st; req_access = acc;
        req_addr = addr; req_wdata = wd; resp_ready = (hold == 0);
        @(posedge clk);
        model_access(ld, st, acc, addr, wd, e.rd, e.f);
        q.push_back(e);
        #1;
        req_valid = 0;
        got_rd = 32'h0;
        got_f  = 1'b0;
        for (int c = 1; c <= WS + 1; c++) begin
            @(negedge clk);
            chk(resp_valid == (c == WS + 1), "resp_latency", {31'b0, resp_valid}, {31'b0, c == WS + 1});
            if (c == WS + 1) begin got_rd = resp_rdata; got_f = resp_fault; end
        end
        chk(got_rd == lit_rd, "lit_rdata", got_rd, lit_rd);
        chk(got_f == lit_f, "lit_fault", {31'b0, got_f}, {31'b0, lit_f});
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); @(negedge clk);
                chk(resp_valid && !req_ready, "hold_resp", {30'b0, resp_valid, req_ready}, 32'h2);
                chk(resp_rdata == got_rd, "hold_stable", resp_rdata, got_rd);
            end
            @(posedge clk); #1;
            resp_ready = 1;
        end
        @(posedge clk); #1;
        chk(req_ready && !resp_valid, "idle_after_resp", {30'b0, req_ready, resp_valid}, 32'h2);
    endtask

    initial begin
        rst = 0; req_valid = 0; req_load = 0; req_store = 0; req_access = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1;
        do_reset(1);
        mon_en = 1;

        do_req(1, 0, 3'b010, 32'h0000_0000, 0, 0, 32'h0000_0000, 0);
        do_req(1, 0, 3'b010, 32'h0000_07FC, 0, 0, 32'h0000_0000, 0);
        do_req(1, 0, 3'b010, 32'h0000_0FFC, 0, 0, 32'h0000_0000, 0);

        do_req(0, 1, 3'b010, 32'h10, 32'h8081_82F3, 0, 32'h0, 0);
        do_req(1, 0, 3'b000, 32'h10, 0, 0, 32'hFFFF_FFF3, 0);
        do_req(1, 0, 3'b100, 32'h10, 0, 0, 32'h0000_00F3, 0);
        do_req(1, 0, 3'b001, 32'h12, 0, 0, 32'hFFFF_8081, 0);
        do_req(1, 0, 3'b101, 32'h12, 0, 0, 32'h0000_8081, 0);
        do_req(1, 0, 3'b000, 32'h13, 0, 0, 32'hFFFF_FF80, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1, 0, 3'b001, 32'h13, 0, 0, 32'h0, 1);
`else
        do_req(1, 0, 3'b001, 32'h13, 0, 0, 32'hFFFF_8081, 0);
`endif

        do_req(0, 1, 3'b010, 32'h20, 32'h1122_3344, 0, 32'h0, 0);
        do_req(0, 1, 3'b000, 32'h21, 32'hFFFF_FF55, 0, 32'h0, 0);
        do_req(1, 0, 3'b010, 32'h20, 0, 0, 32'h1122_5544, 0);

        do_req(1, 0, 3'b010, 32'h20, 0, 5, 32'h1122_5544, 0);
        do_req(1, 0, 3'b101, 32'h22, 0, 0, 32'h0000_1122, 0);

        do_req(0, 1, 3'b010, 32'hFFFF_F004, 32'hA5A5_0F0F, 0, 32'h0, 0);
        do_req(1, 0, 3'b010, 32'h0000_0004, 0, 0, 32'hA5A5_0F0F, 0);

        do_req(0, 1, 3'b010, 32'h30, 32'hCAFE_BABE, 0, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req(1, 0, 3'b010, 32'h31, 0, 0, 32'h0, 1);
        do_req(0, 1, 3'b001, 32'h33, 32'h0000_1234, 0, 32'h0, 1);
        do_req(1, 0, 3'b010, 32'h30, 0, 0, 32'hCAFE_BABE, 0);
`else
        do_req(1, 0, 3'b010, 32'h31, 0, 0, 32'hCAFE_BABE, 0);
        do_req(0, 1, 3'b001, 32'h33, 32'h0000_1234, 0, 32'h0, 0);
        do_req(1, 0, 3'b010, 32'h30, 0, 0, 32'h1234_BABE, 0);
`endif

        do_req(1, 0, 3'b111, 32'h30, 0, 0, 32'h0, 1);
        do_req(1, 0, 3'b011, 32'h30, 0, 0, 32'h0, 1);
        do_req(1, 0, 3'b110, 32'h30, 0, 0, 32'h0, 1);
        do_req(0, 1, 3'b010, 32'h40, 32'h0102_0304, 0, 32'h0, 0);
        do_req(1, 1, 3'b010, 32'h40, 32'hDEAD_BEEF, 0, 32'h0, 1);
        do_req(0, 0, 3'b010, 32'h40, 32'hDEAD_BEEF, 0, 32'h0, 1);
        do_req(0, 1, 3'b011, 32'h40, 32'hDEAD_BEEF, 0, 32'h0, 1);
        do_req(0, 1, 3'b100, 32'h40, 32'hDEAD_BEEF, 0, 32'h0, 1);
        do_req(1, 0, 3'b010, 32'h40, 0, 0, 32'h0102_0304, 0);
        do_req(1, 0, 3'b000, 32'h43, 0, 0, 32'h0000_0001, 0);
        do_req(1, 0, 3'b100, 32'h41, 0, 0, 32'h0000_0003, 0);

        req_valid = 1; req_load = 1; req_store = 0; req_access = 3'b010;
        req_addr = 32'h10; resp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        chk(!resp_valid && !req_ready, "in_wait", {30'b0, resp_valid, req_ready}, 32'h0);
        do_reset(0);
        do_req(1, 0, 3'b010, 32'h10, 0, 0, 32'h0, 0);
        do_req(1, 0, 3'b010, 32'h20, 0, 0, 32'h0, 0);

        chk(q.size() == 0, "queue_drained", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
